// File: rtl/pc_sequencer.sv
// pc_sequencer: selects the program-counter source every cycle.
// Holds the PC at the reset address for RST_CYCLES cycles after reset, then
// arbitrates between illegal-op trap, external interrupt, jump, branch and
// sequential fetch. A taken trap saves the return PC in XP and inserts a single
// bubble cycle before normal fetch resumes.
module pc_sequencer #(
  parameter int RST_CYCLES = 2,  // legal range 1..15
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             stall,
  input  logic             is_br,
  input  logic             br_on_nz,
  input  logic             z,
  input  logic             is_jmp,
  input  logic             ill_op,
  input  logic             irq,
  input  logic             pc_msb,
  output logic [2:0]       PCSEL,
  output logic             pc_en,
  output logic             xp_wr,
  output logic             irq_ack,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] trap_count
);

  localparam logic [2:0] SEL_INCR = 3'b000;
  localparam logic [2:0] SEL_BR   = 3'b001;
  localparam logic [2:0] SEL_JT   = 3'b010;
  localparam logic [2:0] SEL_ILL  = 3'b011;
  localparam logic [2:0] SEL_XADR = 3'b100;
  localparam logic [2:0] SEL_RST  = 3'b101;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_ILL  = 2'b01;
  localparam logic [1:0] CAUSE_IRQ  = 2'b10;

  localparam logic [3:0] BOOT_LOAD = 4'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] boot_cnt;
  logic       irq_s1;
  logic       irq_s2;
  logic       irq_s2_d;
  logic       irq_pend;
  logic       irq_rise;

  assign irq_rise = irq_s2 & ~irq_s2_d;

  // PC source arbitration: outputs follow the current state and this cycle's inputs.
  always_comb begin
    // NOTE: every output gets a default first so no path through the branches
    // below leaves a signal unassigned and infers a latch.
    PCSEL      = SEL_INCR;
    pc_en      = 1'b0;
    xp_wr      = 1'b0;
    irq_ack    = 1'b0;
    trap_cause = CAUSE_NONE;
    unique case (state)
      BOOT: begin
        PCSEL = SEL_RST;
        pc_en = 1'b1;
      end
      RUN: begin
        if (!stall) begin
          pc_en = 1'b1;
          if (ill_op) begin
            PCSEL      = SEL_ILL;
            xp_wr      = 1'b1;
            trap_cause = CAUSE_ILL;
          end else if (irq_pend && !pc_msb) begin
            PCSEL      = SEL_XADR;
            xp_wr      = 1'b1;
            irq_ack    = 1'b1;
            trap_cause = CAUSE_IRQ;
          end else if (is_jmp) begin
            PCSEL = SEL_JT;
          end else if (is_br && (z ^ br_on_nz)) begin
            PCSEL = SEL_BR;
          end
        end
      end
      FLUSH: begin
        // bubble: defaults already freeze the PC
      end
      default: begin
        PCSEL = SEL_RST;
      end
    endcase
  end

  // Sequencer state: boot hold countdown, then RUN with a one-cycle FLUSH after each trap.
  // NOTE: the asynchronous reset sits in the sensitivity list so BOOT is entered
  // the moment RESET_N falls, even without a running clock.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= BOOT;
      boot_cnt <= BOOT_LOAD;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      unique case (state)
        BOOT: begin
          if (boot_cnt == 4'd0) state <= RUN;
          else                  boot_cnt <= boot_cnt - 4'd1;
        end
        RUN: begin
          if (xp_wr) state <= FLUSH;
        end
        FLUSH: begin
          state <= RUN;
        end
        default: begin
          state    <= BOOT;
          boot_cnt <= BOOT_LOAD;
        end
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous irq, plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      irq_s1   <= 1'b0;
      irq_s2   <= 1'b0;
      irq_s2_d <= 1'b0;
    end else begin
      irq_s1   <= irq;
      irq_s2   <= irq_s1;
      irq_s2_d <= irq_s2;
    end
  end

  // Pending interrupt: a new rising edge wins over a same-cycle acceptance.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N)      irq_pend <= 1'b0;
    else if (irq_rise) irq_pend <= 1'b1;
    else if (irq_ack)  irq_pend <= 1'b0;
  end

  // Saturating count of traps taken (one per XP write).
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N)
      trap_count <= '0;
    else if (xp_wr && (trap_count != {CNT_W{1'b1}}))
      trap_count <= trap_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed stimulus, a cycle-level behavioural
// model compared against the DUT on every negative clock edge, and literal
// expectations at the points of interest.
module tb_pc_sequencer;

  localparam int RST_CYCLES = 2;
  localparam int CNT_W      = 2;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             RESET_N;
  logic             stall, is_br, br_on_nz, z, is_jmp, ill_op, irq, pc_msb;
  logic [2:0]       PCSEL;
  logic             pc_en, xp_wr, irq_ack;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] trap_count;

  int total = 0;
  int bad   = 0;
  int acks;

  pc_sequencer #(.RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .RESET_N(RESET_N), .stall(stall), .is_br(is_br),
    .br_on_nz(br_on_nz), .z(z), .is_jmp(is_jmp), .ill_op(ill_op),
    .irq(irq), .pc_msb(pc_msb), .PCSEL(PCSEL), .pc_en(pc_en),
    .xp_wr(xp_wr), .irq_ack(irq_ack), .trap_cause(trap_cause),
    .trap_count(trap_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [2:0] pcsel;
    logic       pc_en;
    logic       xp_wr;
    logic       ack;
    logic [1:0] cause;
  } exp_t;

  int m_boot_left = RST_CYCLES;  // reset-address cycles still to come
  bit m_flush     = 1'b0;        // current cycle is the bubble after a trap
  bit m_pend      = 1'b0;        // interrupt waiting to be taken
  int m_cnt       = 0;           // traps taken, saturating
  bit m_hist[3]   = '{0, 0, 0};  // irq as sampled at the last three edges, newest first

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    if (m_boot_left > 0) begin
      e.pcsel = 3'b101;
      e.pc_en = 1'b1;
    end else if (!m_flush && !stall) begin
      e.pc_en = 1'b1;
      if (ill_op) begin
        e.pcsel = 3'b011; e.xp_wr = 1'b1; e.cause = 2'b01;
      end else if (m_pend && !pc_msb) begin
        e.pcsel = 3'b100; e.xp_wr = 1'b1; e.ack = 1'b1; e.cause = 2'b10;
      end else if (is_jmp) begin
        e.pcsel = 3'b010;
      end else if (is_br && (br_on_nz ? !z : z)) begin
        e.pcsel = 3'b001;
      end
    end
    return e;
  endfunction

  always @(posedge clk or negedge RESET_N) begin
    exp_t e;
    bit   rise;
    if (!RESET_N) begin
      m_boot_left = RST_CYCLES;
      m_flush     = 1'b0;
      m_pend      = 1'b0;
      m_cnt       = 0;
      m_hist      = '{0, 0, 0};
    end else begin
      e    = model_out();
      // the synchronized level lags irq by two edges
      rise = m_hist[1] && !m_hist[2];
      if (m_boot_left > 0) m_boot_left--;
      else if (m_flush)    m_flush = 1'b0;
      else if (e.xp_wr)    m_flush = 1'b1;
      if (e.ack) m_pend = 1'b0;
      if (rise)  m_pend = 1'b1;
      if (e.xp_wr && m_cnt < CNT_MAX) m_cnt++;
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = irq;
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    exp_t e;
    e = model_out();
    check("m_pcsel", 32'(PCSEL), 32'(e.pcsel));
    check("m_pc_en", 32'(pc_en), 32'(e.pc_en));
    check("m_xp_wr", 32'(xp_wr), 32'(e.xp_wr));
    check("m_irq_ack", 32'(irq_ack), 32'(e.ack));
    check("m_cause", 32'(trap_cause), 32'(e.cause));
    check("m_trap_count", 32'(trap_count), 32'(m_cnt));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    RESET_N = 1'b0;
    stall = 0; is_br = 0; br_on_nz = 0; z = 0;
    is_jmp = 1; ill_op = 0; irq = 0; pc_msb = 0;
    tick(); tick();
    at_neg();
    check("rst_pcsel", 32'(PCSEL), 32'h5);
    check("rst_pc_en", 32'(pc_en), 32'h1);
    check("rst_xp_wr", 32'(xp_wr), 32'h0);
    check("rst_cnt", 32'(trap_count), 32'h0);

    // boot hold lasts exactly RST_CYCLES cycles, jump is taken right after
    tick(); RESET_N = 1'b1;
    at_neg(); check("boot0_pcsel", 32'(PCSEL), 32'h5);
    tick(); at_neg(); check("boot1_pcsel", 32'(PCSEL), 32'h5);
    tick(); at_neg(); check("run_jmp_pcsel", 32'(PCSEL), 32'h2);
    check("run_jmp_pc_en", 32'(pc_en), 32'h1);

    // branch polarity
    tick(); is_jmp = 0; is_br = 1; br_on_nz = 0; z = 1;
    at_neg(); check("beq_taken", 32'(PCSEL), 32'h1);
    tick(); z = 0;
    at_neg(); check("beq_not", 32'(PCSEL), 32'h0);
    tick(); br_on_nz = 1; z = 0;
    at_neg(); check("bne_taken", 32'(PCSEL), 32'h1);
    tick(); z = 1;
    at_neg(); check("bne_not", 32'(PCSEL), 32'h0);

    // illegal op beats jump; bubble ignores ill_op and stall
    tick(); is_br = 0; br_on_nz = 0; z = 0; ill_op = 1; is_jmp = 1;
    at_neg();
    check("ill_pcsel", 32'(PCSEL), 32'h3);
    check("ill_xp_wr", 32'(xp_wr), 32'h1);
    check("ill_cause", 32'(trap_cause), 32'h1);
    check("ill_cnt_before", 32'(trap_count), 32'h0);
    tick(); is_jmp = 0; stall = 1;
    at_neg();
    check("flush_pc_en", 32'(pc_en), 32'h0);
    check("flush_xp_wr", 32'(xp_wr), 32'h0);
    check("flush_cnt", 32'(trap_count), 32'h1);
    tick(); ill_op = 0; stall = 0;
    at_neg();
    check("post_flush_pc_en", 32'(pc_en), 32'h1);
    check("post_flush_pcsel", 32'(PCSEL), 32'h0);

    // interrupt deferred while in supervisor mode
    tick(); pc_msb = 1; irq = 1;
    tick(); irq = 0;
    repeat (10) tick();
    at_neg(); check("sup_no_ack", 32'(irq_ack), 32'h0);
    tick(); pc_msb = 0;
    at_neg();
    check("irq_ack", 32'(irq_ack), 32'h1);
    check("irq_pcsel", 32'(PCSEL), 32'h4);
    check("irq_cause", 32'(trap_cause), 32'h2);
    tick(); at_neg();
    check("irq_flush_en", 32'(pc_en), 32'h0);
    check("irq_flush_ack", 32'(irq_ack), 32'h0);
    repeat (3) tick();

    // a held level yields one acknowledge only
    tick(); irq = 1; acks = 0;
    repeat (12) begin
      at_neg();
      acks += int'(irq_ack);
      tick();
    end
    check("held_one_ack", 32'(acks), 32'h1);
    irq = 0;
    repeat (4) tick();

    // stall freezes everything; ill_op wins, then the pending interrupt
    stall = 1; ill_op = 1; irq = 1;
    tick(); irq = 0;
    repeat (4) tick();
    at_neg();
    check("stall_pc_en", 32'(pc_en), 32'h0);
    check("stall_pcsel", 32'(PCSEL), 32'h0);
    check("stall_xp_wr", 32'(xp_wr), 32'h0);
    tick(); stall = 0;
    at_neg(); check("stall_drop_ill", 32'(PCSEL), 32'h3);
    tick(); ill_op = 0;
    at_neg(); check("stall_bubble_en", 32'(pc_en), 32'h0);
    tick(); at_neg();
    check("late_irq_pcsel", 32'(PCSEL), 32'h4);
    check("late_irq_ack", 32'(irq_ack), 32'h1);
    tick(); at_neg(); check("late_irq_flush", 32'(pc_en), 32'h0);
    check("cnt_saturated", 32'(trap_count), 32'h3);

    // pending interrupt plus supervisor-mode trap, then reset mid-bubble
    tick(); pc_msb = 1; irq = 1;
    repeat (5) tick();
    ill_op = 1;
    at_neg(); check("sup_ill_pcsel", 32'(PCSEL), 32'h3);
    tick(); ill_op = 0; irq = 0;
    at_neg(); check("pre_rst_flush", 32'(pc_en), 32'h0);
    tick(); RESET_N = 1'b0;
    at_neg();
    check("mid_flush_rst_pcsel", 32'(PCSEL), 32'h5);
    check("mid_flush_rst_cnt", 32'(trap_count), 32'h0);
    tick(); tick(); RESET_N = 1'b1; pc_msb = 0;
    at_neg(); check("reboot0", 32'(PCSEL), 32'h5);
    tick(); at_neg(); check("reboot1", 32'(PCSEL), 32'h5);
    tick(); at_neg();
    check("pend_dropped_ack", 32'(irq_ack), 32'h0);
    check("pend_dropped_pcsel", 32'(PCSEL), 32'h0);

    // five illegal-op traps saturate a 2-bit counter at 3
    repeat (5) begin
      tick(); ill_op = 1;
      tick(); ill_op = 0;
    end
    at_neg(); check("sat_cnt", 32'(trap_count), 32'h3);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
